bcd_dec_driver: RTL and testbench

- Inverse of the 9-input active-low priority encoder (I_n[8:0] -> Y_n[3:0]): takes active-low BCD codes in the encoder's output format and regenerates active-low decimal lines in its input format.
- Codes arrive on a valid/ready handshake and are buffered in a small FIFO.
- Each code is driven as a one-cold pattern for a programmable hold time, then a programmable blank gap.
- Used as a stimulus/loop-back source for the encoder and as a decimal indicator driver.

---
 rtl/bcd_dec_driver.sv | 148 ++++++++++++++
 tb/tb_bcd_dec_driver.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_dec_driver.sv
// bcd_dec_driver: turns active-low BCD codes (the 9-input priority encoder's
// output format) back into one-cold active-low decimal lines. Codes are
// queued in a small FIFO. Each digit is driven for HOLD_CYCLES cycles and
// followed by GAP_CYCLES blank (all-ones) cycles.
module bcd_dec_driver #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 2,
  parameter int CW          = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [3:0]    y_n_in,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [8:0]    i_n_out,
  output logic          strobe,
  output logic          busy,
  output logic          err_invalid,
  output logic [CW-1:0] done_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CMAX  = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W = $clog2(CMAX + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [8:0] BLANK = 9'h1FF;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic [3:0]       mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             pop_slot;
  logic [3:0]       head;
  logic [9:0]       head_dec;

  // Returns {valid, one-cold pattern}. Digit zero is valid but lights no line.
  function automatic logic [9:0] decode(input logic [3:0] code);
    logic [3:0] d;
    d = ~code;
    decode = {1'b0, BLANK};
    if (d == 4'd0)
      decode = {1'b1, BLANK};
    else if (d <= 4'd9)
      decode = {1'b1, ~(9'h001 << (d - 4'd1))};
  endfunction

  // The extra pointer bit separates full from empty when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // in_ready comes only from the pointer flops, so a same-cycle pop cannot
  // open a slot in a full FIFO.
  assign in_ready = ~full;
  assign push     = in_valid & in_ready;
  assign pop      = pop_slot & ~empty;
  assign head     = mem[rd_ptr[AW-1:0]];
  assign head_dec = decode(head);
  assign busy     = (state != IDLE) | ~empty;

  // The FSM may take a new code when idle, or on the last cycle of GAP. With
  // no gap configured, it may also take one on the last cycle of HOLD.
  always_comb begin
    pop_slot = 1'b0;
    case (state)
      IDLE:    pop_slot = 1'b1;
      HOLD:    pop_slot = (cnt == '0) && (GAP_CYCLES == 0);
      GAP:     pop_slot = (cnt == '0);
      default: pop_slot = 1'b0;
    endcase
  end

  // FIFO pointers; reset flushes the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage; holds data only, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= y_n_in;
  end

  // Hold/gap sequencer with registered outputs. A pop later in this block
  // overrides the HOLD/GAP exit assignments made earlier in the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      i_n_out     <= BLANK;
      strobe      <= 1'b0;
      err_invalid <= 1'b0;
      done_cnt    <= '0;
    end else begin
      strobe <= 1'b0;
      case (state)
        IDLE: ;
        HOLD: begin
          if (cnt == '0) begin
            done_cnt <= done_cnt + CW'(1);
            i_n_out  <= BLANK;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              cnt   <= GAP_LOAD;
            end else begin
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt == '0) state <= IDLE;
          else           cnt   <= cnt - CNT_W'(1);
        end
        default: state <= IDLE;
      endcase

      if (pop) begin
        if (head_dec[9]) begin
          i_n_out <= head_dec[8:0];
          strobe  <= 1'b1;
          cnt     <= HOLD_LOAD;
          state   <= HOLD;
        end else begin
          // Bad code: flag it and stay idle so the next entry pops at once.
          err_invalid <= 1'b1;
          i_n_out     <= BLANK;
          state       <= IDLE;
        end
      end
    end
  end

endmodule

// File: tb/tb_bcd_dec_driver.sv
// Testbench for bcd_dec_driver. Instance A uses the default timing
// (hold 8, gap 2). Instance B uses hold 3, no gap and a 2-bit done counter.
module tb_bcd_dec_driver;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a, rst_b;
  logic [3:0] y_a, y_b;
  logic       in_valid_a, in_valid_b;
  logic       in_ready_a, in_ready_b;
  logic [8:0] i_n_out_a, i_n_out_b;
  logic       strobe_a, strobe_b;
  logic       busy_a, busy_b;
  logic       err_a, err_b;
  logic [7:0] done_cnt_a;
  logic [1:0] done_cnt_b;

  bcd_dec_driver #(.DEPTH(4), .HOLD_CYCLES(8), .GAP_CYCLES(2), .CW(8)) dut_a (
    .clk(clk), .rst(rst_a), .y_n_in(y_a), .in_valid(in_valid_a),
    .in_ready(in_ready_a), .i_n_out(i_n_out_a), .strobe(strobe_a),
    .busy(busy_a), .err_invalid(err_a), .done_cnt(done_cnt_a)
  );

  bcd_dec_driver #(.DEPTH(4), .HOLD_CYCLES(3), .GAP_CYCLES(0), .CW(2)) dut_b (
    .clk(clk), .rst(rst_b), .y_n_in(y_b), .in_valid(in_valid_b),
    .in_ready(in_ready_b), .i_n_out(i_n_out_b), .strobe(strobe_b),
    .busy(busy_b), .err_invalid(err_b), .done_cnt(done_cnt_b)
  );

  typedef struct {
    logic [3:0] code;
    bit         ok;
    logic [8:0] pat;
  } vec_t;

  int         total = 0;
  int         bad   = 0;
  logic [8:0] sb_a[$];
  logic [8:0] sb_b[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Scoreboard: every strobe must match the oldest expected pattern.
  always @(negedge clk) begin
    if (strobe_a) begin
      if (sb_a.size() == 0) check("sb_a_strobe_unexpected", strobe_a, 0);
      else                  check("sb_a_pattern", i_n_out_a, sb_a.pop_front());
    end
    if (strobe_b) begin
      if (sb_b.size() == 0) check("sb_b_strobe_unexpected", strobe_b, 0);
      else                  check("sb_b_pattern", i_n_out_b, sb_b.pop_front());
    end
  end

  task automatic push_a(input logic [3:0] code, input bit ok, input logic [8:0] pat);
    int n = 0;
    while (!in_ready_a && n < 200) begin @(negedge clk); n++; end
    check("push_a_ready", in_ready_a, 1);
    in_valid_a = 1'b1;
    y_a = code;
    if (ok) sb_a.push_back(pat);
    @(posedge clk);
    #1 in_valid_a = 1'b0;
  endtask

  task automatic push_b(input logic [3:0] code, input bit ok, input logic [8:0] pat);
    int n = 0;
    while (!in_ready_b && n < 200) begin @(negedge clk); n++; end
    check("push_b_ready", in_ready_b, 1);
    in_valid_b = 1'b1;
    y_b = code;
    if (ok) sb_b.push_back(pat);
    @(posedge clk);
    #1 in_valid_b = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy_a && n < budget) begin @(negedge clk); n++; end
    check("idle_a", busy_a, 0);
  endtask

  task automatic wait_idle_b(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy_b && n < budget) begin @(negedge clk); n++; end
    check("idle_b", busy_b, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t       tbl[16];
    logic [3:0] fc[6];
    logic [8:0] fp[6];
    logic [3:0] bc[3];
    logic [8:0] bp[3];
    logic [8:0] exp_tr[14];
    logic       exp_st[14];
    logic [8:0] tr_p[14];
    logic       tr_s[14];
    int         exp_done;
    bit         exp_err;
    int         acc;
    int         n;
    int         len;
    logic       rdy;

    tbl[0]  = '{4'b1111, 1'b1, 9'h1FF};
    tbl[1]  = '{4'b1110, 1'b1, 9'h1FE};
    tbl[2]  = '{4'b1101, 1'b1, 9'h1FD};
    tbl[3]  = '{4'b1100, 1'b1, 9'h1FB};
    tbl[4]  = '{4'b1011, 1'b1, 9'h1F7};
    tbl[5]  = '{4'b1010, 1'b1, 9'h1EF};
    tbl[6]  = '{4'b1001, 1'b1, 9'h1DF};
    tbl[7]  = '{4'b1000, 1'b1, 9'h1BF};
    tbl[8]  = '{4'b0111, 1'b1, 9'h17F};
    tbl[9]  = '{4'b0110, 1'b1, 9'h0FF};
    tbl[10] = '{4'b0101, 1'b0, 9'h1FF};
    tbl[11] = '{4'b0100, 1'b0, 9'h1FF};
    tbl[12] = '{4'b0011, 1'b0, 9'h1FF};
    tbl[13] = '{4'b0010, 1'b0, 9'h1FF};
    tbl[14] = '{4'b0001, 1'b0, 9'h1FF};
    tbl[15] = '{4'b0000, 1'b0, 9'h1FF};

    fc = '{4'b1110, 4'b1101, 4'b1100, 4'b1011, 4'b1010, 4'b1001};
    fp = '{9'h1FE, 9'h1FD, 9'h1FB, 9'h1F7, 9'h1EF, 9'h1DF};
    bc = '{4'b1110, 4'b1101, 4'b1100};
    bp = '{9'h1FE, 9'h1FD, 9'h1FB};
    exp_tr = '{9'h1FF, 9'h1FF, 9'h1FE, 9'h1FE, 9'h1FE, 9'h1FD, 9'h1FD,
               9'h1FD, 9'h1FB, 9'h1FB, 9'h1FB, 9'h1FF, 9'h1FF, 9'h1FF};
    exp_st = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 0};

    rst_a = 1'b1; rst_b = 1'b1;
    in_valid_a = 1'b0; in_valid_b = 1'b0;
    y_a = 4'hF; y_b = 4'hF;
    repeat (3) @(posedge clk);
    #1 rst_a = 1'b0; rst_b = 1'b0;
    @(negedge clk);

    check("rst_i_n_out", i_n_out_a, 9'h1FF);
    check("rst_strobe", strobe_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_err", err_a, 0);
    check("rst_done", done_cnt_a, 0);
    check("rst_ready", in_ready_a, 1);
    check("rst_b_ready", in_ready_b, 1);
    check("rst_b_i_n_out", i_n_out_b, 9'h1FF);

    // Digit 5: latency, hold length, gap length, completion count.
    in_valid_a = 1'b1; y_a = 4'b1010; sb_a.push_back(9'h1EF);
    @(posedge clk);
    #1 in_valid_a = 1'b0;
    @(negedge clk);
    check("d5_pre_out", i_n_out_a, 9'h1FF);
    check("d5_pre_busy", busy_a, 1);
    @(negedge clk);
    check("d5_strobe", strobe_a, 1);
    len = 0;
    while (i_n_out_a === 9'h1EF && len < 20) begin len++; @(negedge clk); end
    check("d5_hold_len", len, 8);
    check("d5_gap1_out", i_n_out_a, 9'h1FF);
    check("d5_gap1_busy", busy_a, 1);
    check("d5_done_at_exit", done_cnt_a, 1);
    @(negedge clk);
    check("d5_gap2_busy", busy_a, 1);
    @(negedge clk);
    check("d5_idle_busy", busy_a, 0);
    exp_done = 1;

    // Digit 8 then digit 0, back to back.
    push_a(4'b0111, 1'b1, 9'h17F);
    push_a(4'b1111, 1'b1, 9'h1FF);
    wait_idle_a(100);
    exp_done += 2;
    check("d8d0_done", done_cnt_a, exp_done);
    check("d8d0_sb_empty", sb_a.size(), 0);

    // Hold in_valid high for six codes into a depth-4 FIFO.
    acc = 0;
    in_valid_a = 1'b1; y_a = fc[0];
    for (int c = 0; c < 8; c++) begin
      rdy = in_ready_a;
      @(posedge clk);
      if (rdy) begin sb_a.push_back(fp[acc]); acc++; end
      #1;
      if (acc < 6) y_a = fc[acc]; else in_valid_a = 1'b0;
      @(negedge clk);
    end
    check("full_accepted", acc, 5);
    check("full_ready_low", in_ready_a, 0);
    n = 0;
    while (acc < 6 && n < 100) begin
      rdy = in_ready_a;
      @(posedge clk);
      if (rdy) begin sb_a.push_back(fp[acc]); acc++; end
      #1;
      if (acc < 6) y_a = fc[acc]; else in_valid_a = 1'b0;
      @(negedge clk);
      n++;
    end
    check("full_all_accepted", acc, 6);
    in_valid_a = 1'b0;
    wait_idle_a(300);
    exp_done += 6;
    check("full_done", done_cnt_a, exp_done);
    check("full_sb_empty", sb_a.size(), 0);

    // Decode table: every code, one at a time.
    exp_err = 1'b0;
    for (int i = 0; i < 16; i++) begin
      push_a(tbl[i].code, tbl[i].ok, tbl[i].pat);
      wait_idle_a(100);
      if (tbl[i].ok) exp_done++;
      else           exp_err = 1'b1;
      check($sformatf("tbl%0d_done", i), done_cnt_a, exp_done & 255);
      check($sformatf("tbl%0d_err", i), err_a, exp_err);
    end

    // Error flag is sticky across a later valid digit.
    push_a(4'b1110, 1'b1, 9'h1FE);
    wait_idle_a(100);
    exp_done++;
    check("after_err_done", done_cnt_a, exp_done & 255);
    check("after_err_sticky", err_a, 1);

    // Reset in the middle of digit 9 with two more codes queued.
    push_a(4'b0110, 1'b1, 9'h0FF);
    push_a(4'b1101, 1'b1, 9'h1FD);
    push_a(4'b1100, 1'b1, 9'h1FB);
    @(negedge clk);
    n = 0;
    while (i_n_out_a !== 9'h0FF && n < 50) begin @(negedge clk); n++; end
    check("rsthold_seen", i_n_out_a, 9'h0FF);
    @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk);
    #1 rst_a = 1'b0;
    sb_a.delete();
    @(negedge clk);
    check("rsthold_out", i_n_out_a, 9'h1FF);
    check("rsthold_busy", busy_a, 0);
    check("rsthold_done", done_cnt_a, 0);
    check("rsthold_ready", in_ready_a, 1);
    check("rsthold_err", err_a, 0);
    repeat (30) @(negedge clk);
    check("rsthold_quiet_out", i_n_out_a, 9'h1FF);
    check("rsthold_quiet_done", done_cnt_a, 0);
    check("rsthold_quiet_busy", busy_a, 0);

    // No-gap instance: digits 1,2,3 back to back with no blank cycle.
    @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      tr_p[i] = i_n_out_b;
      tr_s[i] = strobe_b;
      if (i < 3) begin
        in_valid_b = 1'b1; y_b = bc[i]; sb_b.push_back(bp[i]);
      end else begin
        in_valid_b = 1'b0;
      end
      @(negedge clk);
    end
    for (int i = 0; i < 14; i++) begin
      check($sformatf("b_trace%0d_out", i), tr_p[i], exp_tr[i]);
      check($sformatf("b_trace%0d_strobe", i), tr_s[i], exp_st[i]);
    end
    check("b_done3", done_cnt_b, 3);
    check("b_busy", busy_b, 0);

    // done_cnt wraps from 3 to 0 with a 2-bit counter.
    push_b(4'b1011, 1'b1, 9'h1F7);
    wait_idle_b(100);
    check("b_done_wrap", done_cnt_b, 0);
    check("b_err", err_b, 0);

    check("end_sb_a_empty", sb_a.size(), 0);
    check("end_sb_b_empty", sb_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
